// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter with a start/ready handshake, a one-cycle done pulse
//   on completion, and optional auto-reload for periodic operation.
//
//   Parameters
//     WIDTH  counter / load-value width in bits
//     P      decrement per enabled tick (1 <= P < 2**WIDTH)
//
//   Ports
//     clk       in   clock, all state changes on posedge
//     reset     in   synchronous, active-high
//     start     in   load request, accepted only while ready=1
//     load_val  in   start count, sampled on accept
//     reload    in   auto-reload mode, sampled on accept
//     tick_en   in   count enable while running
//     abort     in   cancel a running count (no done pulse)
//     ready     out  high while idle
//     busy      out  high while running
//     value     out  current count (registered)
//     done      out  registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module countdown_timer #(
   parameter int WIDTH = 24,
   parameter int P     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             reload,
   input  logic             tick_en,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] value,
   output logic             done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Step as an unsigned WIDTH-bit constant for both compare and subtract.
   localparam logic [WIDTH-1:0] STEP = WIDTH'(P);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] reload_val_q, reload_val_d;
   logic             auto_q, auto_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         value_q      <= '0;
         reload_val_q <= '0;
         auto_q       <= 1'b0;
         done_q       <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         value_q      <= value_d;
         reload_val_q <= reload_val_d;
         auto_q       <= auto_d;
         done_q       <= done_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      value_d      = value_q;
      reload_val_d = reload_val_q;
      auto_d       = auto_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               value_d      = load_val;
               reload_val_d = load_val;
               auto_d       = reload;
               // A zero start count completes immediately without running.
               if (load_val == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               value_d = '0;
            end else if (tick_en) begin
               if (value_q > STEP) begin
                  value_d = value_q - STEP;
               end else begin
                  // Terminal tick: clamp instead of wrapping; remainder dropped.
                  done_d = 1'b1;
                  if (auto_q) begin
                     value_d = reload_val_q;
                  end else begin
                     value_d = '0;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            value_d = '0;
         end
      endcase

      // Status flags are registered copies of the next state.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d == RUN);
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign value = value_q;
   assign done  = done_q;

endmodule
